vlog_tap_scheduler: RTL
=======================

VLOG_TAP_SCHEDULER -- requirements
Module: vlog_tap_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4: number of result requesters (checkers) sharing one TAP result channel; range 1-32.
REQ-002 Parameter NUM_TESTS, default 16: TAP plan count, the total number of testcases to emit; must be 1 or greater.
REQ-003 Parameter TCW, default 16: width of testcase index and counters; must satisfy 2^TCW > NUM_TESTS.
REQ-004 Parameter IDW, default 2: requester-ID width; must satisfy 2^IDW >= NUM_REQ.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 req_valid_i  in  NUM_REQ  per-requester "result pending".
REQ-008 req_ok_i  in  NUM_REQ  per-requester result: 1 = ok, 0 = not ok; sampled with its valid.
REQ-009 req_ready_o  out  NUM_REQ  one-hot accept strobe; result is consumed when valid and ready are both high.
REQ-010 plan_valid_o  out  1  plan header pending.
REQ-011 plan_count_o  out  TCW  equal to NUM_TESTS; constant.
REQ-012 tc_valid_o  out  1  testcase record pending.
REQ-013 tc_index_o  out  TCW  1-based testcase number of the current record.
REQ-014 tc_ok_o  out  1  ok or not-ok flag of the current record.
REQ-015 tc_src_o  out  IDW  ID of the requester that produced the current record.
REQ-016 tc_ready_i  in  1  downstream writer accepts the plan header or record.
REQ-017 done_o  out  1  all NUM_TESTS records have been handed off.
REQ-018 overrun_o  out  1  sticky: a result arrived after the plan was exhausted.

Function
REQ-019 The FSM SHALL have the states PLAN, ARB, EMIT and DONE; reset enters PLAN.
REQ-020 PLAN: plan_valid_o=1; on tc_ready_i=1 the FSM goes to ARB and plan_valid_o drops the next cycle. No record is emitted before the plan handshake.
REQ-021 ARB, no req_valid_i: stay in ARB; req_ready_o=0.
REQ-022 ARB, any req_valid_i:
- grant goes to the first valid requester at or after the round-robin pointer, wrapping at NUM_REQ-1 to 0;
- req_ready_o is combinationally one-hot for the winner in the same cycle;
- tc_ok_o, tc_src_o and tc_index_o=count+1 are registered;
- pointer becomes winner+1, modulo NUM_REQ;
- next state is EMIT.
REQ-023 EMIT: tc_valid_o=1 and the record SHALL stay stable until tc_ready_i=1.
- On the handshake, count increments.
- If the new count equals NUM_TESTS, go to DONE; otherwise go to ARB.
REQ-024 req_ready_o SHALL be 0 in PLAN and EMIT; accepting a record costs at least 2 cycles, so peak rate is 1 record per 2 cycles.
REQ-025 DONE: done_o=1 and tc_valid_o=0.
- Every req_valid_i is accepted immediately: req_ready_o equals req_valid_i, all bits at once.
- Results accepted here are discarded and set overrun_o.
REQ-026 Fairness: with all requesters continuously valid, grants SHALL rotate 0,1,...,NUM_REQ-1,0.
REQ-027 With NUM_REQ=1 the pointer is constant 0 and tc_src_o=0.
REQ-028 An input req_valid_i SHALL remain asserted, with stable req_ok_i, until its ready is seen; a deasserted valid is simply not granted, and no error is flagged.

Reset
REQ-029 Asserting rst SHALL asynchronously set:
- state to PLAN and count to 0;
- pointer to 0 and overrun_o to 0;
- tc_valid_o, tc_ok_o, tc_src_o, tc_index_o and done_o to 0;
- plan_valid_o to 1 once rst deasserts.
REQ-030 Reset mid-EMIT SHALL drop the pending record without a handshake; after release the sequence restarts with a new plan header.
REQ-031 req_ready_o SHALL be 0 throughout reset.

Configuration
REQ-032 Macro VLOG_TAP_SCHEDULER_SUMMARY_EN, when defined, SHALL add the outputs pass_cnt_o (TCW) and fail_cnt_o (TCW).
- Each counts emitted records by tc_ok_o value at the EMIT handshake.
- Both reset to 0, and pass_cnt_o+fail_cnt_o equals count at all times.
- DONE-state discards are not counted.
REQ-033 When the macro is undefined, those ports and counters SHALL not exist; all other behaviour is identical.

Verification
REQ-034 Reset, tc_ready_i=1 -> plan_valid_o=1 for 1 cycle with plan_count_o=16; no tc_valid_o before it.
REQ-035 All 4 requesters valid, ok pattern 1,0,1,1, tc_ready_i=1 -> records with index 1,2,3,4, src 0,1,2,3, ok 1,0,1,1, one every 2 cycles.
REQ-036 tc_ready_i held 0 for 5 cycles in EMIT -> tc_valid_o stays 1 and record unchanged; req_ready_o=0 throughout.
REQ-037 16 records accepted -> done_o=1; a later req_valid_i[2] pulse -> req_ready_o[2]=1 and overrun_o=1 sticky.
REQ-038 rst pulsed while EMIT holds index 5 -> outputs cleared at once; after release plan_valid_o=1 and the next record index is 1, src chosen from pointer 0.
REQ-039 With VLOG_TAP_SCHEDULER_SUMMARY_EN defined, 10 ok and 6 not-ok results -> pass_cnt_o=10 and fail_cnt_o=6 at done_o.

Source files
------------

// File: rtl/vlog_tap_scheduler.sv
// ---------------------------------------------------------------------------
// vlog_tap_scheduler
//
// Collects pass/fail results from NUM_REQ checkers and serialises them into a
// TAP-style stream: one plan header ("1..NUM_TESTS") followed by NUM_TESTS
// numbered testcase records. Requesters are served round-robin. Once the plan
// is exhausted, late results are swallowed and flagged as an overrun.
//
// Optional feature (macro VLOG_TAP_SCHEDULER_SUMMARY_EN):
//   adds pass_cnt_o / fail_cnt_o, the running ok / not-ok tallies of the
//   records handed off downstream.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   req_valid_i     per-requester result pending
//   req_ok_i        per-requester result value (1 = ok)
//   req_ready_o     one-hot accept strobe (all-valid echo once done)
//   plan_valid_o    plan header pending
//   plan_count_o    constant NUM_TESTS
//   tc_valid_o      testcase record pending
//   tc_index_o      1-based testcase number of the record
//   tc_ok_o         ok flag of the record
//   tc_src_o        requester ID that produced the record
//   tc_ready_i      downstream accepts header or record
//   done_o          all NUM_TESTS records handed off
//   overrun_o       sticky: a result arrived after the plan was exhausted
//   pass_cnt_o      (optional) records emitted with ok = 1
//   fail_cnt_o      (optional) records emitted with ok = 0
// ---------------------------------------------------------------------------
module vlog_tap_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int NUM_TESTS = 16,
  parameter int TCW       = 16,
  parameter int IDW       = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_valid_i,
  input  logic [NUM_REQ-1:0] req_ok_i,
  output logic [NUM_REQ-1:0] req_ready_o,
  output logic               plan_valid_o,
  output logic [TCW-1:0]     plan_count_o,
  output logic               tc_valid_o,
  output logic [TCW-1:0]     tc_index_o,
  output logic               tc_ok_o,
  output logic [IDW-1:0]     tc_src_o,
  input  logic               tc_ready_i,
  output logic               done_o,
  output logic               overrun_o
`ifdef VLOG_TAP_SCHEDULER_SUMMARY_EN
  ,
  output logic [TCW-1:0]     pass_cnt_o,
  output logic [TCW-1:0]     fail_cnt_o
`endif
);

  localparam logic [TCW-1:0] NUM_TESTS_W = TCW'(NUM_TESTS);
  localparam logic [IDW:0]   NUM_REQ_W   = (IDW+1)'(NUM_REQ);

  typedef enum logic [1:0] {
    ST_PLAN,
    ST_ARB,
    ST_EMIT,
    ST_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [TCW-1:0]     count_q;
  logic [TCW-1:0]     count_inc;
  logic [IDW-1:0]     ptr_q;
  logic [IDW-1:0]     ptr_nxt;

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic                 grant_found;
  logic [IDW-1:0]       grant_off;
  logic [IDW:0]         winner_sum;
  logic [IDW:0]         winner_wrap;
  logic [IDW-1:0]       grant_idx;
  logic [IDW:0]         ptr_sum;
  logic [IDW:0]         ptr_wrap;
  logic [NUM_REQ-1:0]   grant_onehot;
  logic                 grant_ok;
  logic                 emit_hs;

  assign count_inc = count_q + TCW'(1);
  assign emit_hs   = (state_q == ST_EMIT) && tc_ready_i;

  // Rotate the request vector so the round-robin pointer sits at bit 0;
  // the lowest set bit of the rotated vector is then the winner's offset
  // from the pointer, which naturally handles the wrap from NUM_REQ-1 to 0.
  assign req_dbl = {req_valid_i, req_valid_i};
  assign req_rot = NUM_REQ'(req_dbl >> ptr_q);

  // Priority encode the rotated vector. Scanning downward lets the lowest
  // offset overwrite any higher one, so the nearest requester wins.
  always_comb begin
    grant_found = 1'b0;
    grant_off   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        grant_found = 1'b1;
        grant_off   = IDW'(i);
      end
    end
  end

  // Convert offset back to an absolute requester ID and derive the pointer
  // for the next round (winner + 1, modulo NUM_REQ). The pointer is always
  // below NUM_REQ, so one conditional subtraction is enough for the modulo.
  always_comb begin
    winner_sum   = {1'b0, ptr_q} + {1'b0, grant_off};
    winner_wrap  = (winner_sum >= NUM_REQ_W) ? (winner_sum - NUM_REQ_W) : winner_sum;
    grant_idx    = winner_wrap[IDW-1:0];
    ptr_sum      = {1'b0, grant_idx} + (IDW+1)'(1);
    ptr_wrap     = (ptr_sum >= NUM_REQ_W) ? (ptr_sum - NUM_REQ_W) : ptr_sum;
    ptr_nxt      = ptr_wrap[IDW-1:0];
    grant_onehot = grant_found ? (NUM_REQ'(1) << grant_idx) : '0;
    grant_ok     = |(req_ok_i & grant_onehot);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_PLAN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and accept-strobe logic. Requesters are only ever accepted in
  // ARB (one winner) or DONE (everything, to drain late results).
  always_comb begin
    state_d     = state_q;
    req_ready_o = '0;
    case (state_q)
      ST_PLAN: begin
        if (tc_ready_i) state_d = ST_ARB;
      end
      ST_ARB: begin
        if (grant_found) begin
          req_ready_o = grant_onehot;
          state_d     = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (tc_ready_i) state_d = (count_inc == NUM_TESTS_W) ? ST_DONE : ST_ARB;
      end
      ST_DONE: begin
        req_ready_o = req_valid_i;
      end
      default: state_d = ST_PLAN;
    endcase
  end

  // Status outputs decode directly from the state register.
  assign plan_valid_o = (state_q == ST_PLAN);
  assign tc_valid_o   = (state_q == ST_EMIT);
  assign done_o       = (state_q == ST_DONE);
  assign plan_count_o = NUM_TESTS_W;

  // Record capture, handed-off count, round-robin pointer and overrun flag.
  // The record is loaded at the grant and held untouched through EMIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= '0;
      ptr_q      <= '0;
      tc_index_o <= '0;
      tc_ok_o    <= 1'b0;
      tc_src_o   <= '0;
      overrun_o  <= 1'b0;
    end else begin
      if (state_q == ST_ARB && grant_found) begin
        tc_index_o <= count_inc;
        tc_ok_o    <= grant_ok;
        tc_src_o   <= grant_idx;
        ptr_q      <= ptr_nxt;
      end
      if (emit_hs) begin
        count_q <= count_inc;
      end
      if (state_q == ST_DONE && (|req_valid_i)) begin
        overrun_o <= 1'b1;
      end
    end
  end

`ifdef VLOG_TAP_SCHEDULER_SUMMARY_EN
  // Pass/fail tallies advance only on the downstream handshake, so their
  // sum always tracks the handed-off count; DONE-state discards are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_cnt_o <= '0;
      fail_cnt_o <= '0;
    end else if (emit_hs) begin
      if (tc_ok_o) pass_cnt_o <= pass_cnt_o + TCW'(1);
      else         fail_cnt_o <= fail_cnt_o + TCW'(1);
    end
  end
`endif

endmodule
